// File: rtl/ysyx_22040750_ifu_pc_pkg.sv
// Shared definitions for the IFU PC / fetch block: state encoding, defaults, helpers.
package ysyx_22040750_ifu_pc_pkg;

  // Fetch sequencer states (binary encoded)
  typedef enum logic [2:0] {
    S_REQ  = 3'd0,  // issue imem request for pc
    S_RSP  = 3'd1,  // wait for the response strobe
    S_DROP = 3'd2,  // flushed while outstanding: swallow the response
    S_OUT  = 3'd3,  // present {inst, pc, snpc} to IF/ID
    S_NPC  = 3'd4   // wait for the next pc from the dnpc producer
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam int          IFU_ILEN_BYTES = 4;

  // Instruction addresses are word aligned; low bits are dropped on accept
  function automatic logic [31:0] ifu_align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040750_ifu_pc.sv
// Architectural PC holder and single-outstanding instruction fetcher.
// One request per PC; the next PC is only taken once the current instruction
// has been handed to IF/ID (or flushed).
module ysyx_22040750_ifu_pc
  import ysyx_22040750_ifu_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
  parameter int          ILEN_BYTES = IFU_ILEN_BYTES
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_dnpc_valid,
  output logic        O_dnpc_ready,
  input  logic [31:0] I_dnpc,
  output logic        O_imem_req,
  input  logic        I_imem_gnt,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_rvalid,
  input  logic [31:0] I_imem_rdata,
  output logic        O_IF_ID_valid,
  input  logic        I_IF_ID_ready,
  output logic [31:0] O_inst,
  output logic [31:0] O_pc,
  output logic [31:0] O_snpc,
  input  logic        I_flush,
  output logic        O_misalign
);

  ifu_state_e  state, state_nxt;
  logic        live;       // low while in reset and for the first cycle after release
  logic [31:0] pc;
  logic [31:0] inst;
  logic        misalign;

  // Gate the request until one edge after reset release so nothing is
  // driven to memory while reset is (or has just been) asserted
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_REQ;
    else          state <= state_nxt;
  end

  // Next-state logic; flush dominates any same-cycle handshake except dnpc accept
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (live) begin
          if (I_flush)         state_nxt = S_NPC;
          else if (I_imem_gnt) state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        // Flush with the response in the same cycle: the response is consumed
        // and dropped here, so there is nothing left to wait for in S_DROP
        if (I_flush)            state_nxt = I_imem_rvalid ? S_NPC : S_DROP;
        else if (I_imem_rvalid) state_nxt = S_OUT;
      end
      S_DROP: if (I_imem_rvalid)               state_nxt = S_NPC;
      S_OUT:  if (I_flush || I_IF_ID_ready)    state_nxt = S_NPC;
      S_NPC:  if (I_dnpc_valid)                state_nxt = S_REQ;
      default:                                 state_nxt = S_REQ;
    endcase
  end

  // Instruction capture on an un-flushed response
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)                                           inst <= '0;
    else if (state == S_RSP && I_imem_rvalid && !I_flush)   inst <= I_imem_rdata;
  end

  // PC update and sticky misalign flag on dnpc accept
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (state == S_NPC && I_dnpc_valid) begin
      pc       <= ifu_align_pc(I_dnpc);
      misalign <= misalign | (|I_dnpc[1:0]);
    end
  end

  // Handshake outputs are pure state decodes
  assign O_imem_req    = live && (state == S_REQ);
  assign O_dnpc_ready  = (state == S_NPC);
  assign O_IF_ID_valid = (state == S_OUT);
  assign O_imem_addr   = pc;
  assign O_pc          = pc;
  assign O_snpc        = pc + 32'(ILEN_BYTES);
  assign O_inst        = inst;
  assign O_misalign    = misalign;

endmodule

// File: tb/tb_ysyx_22040750_ifu_pc.sv
// Bench for the IFU PC block: directed scenarios plus a randomized run, with a
// scoreboard fed by the stimulus side and drained by an independent monitor.
module tb_ysyx_22040750_ifu_pc;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dnpc_valid = 1'b0;
  logic        dnpc_ready;
  logic [31:0] dnpc = '0;
  logic        imem_req;
  logic        gnt = 1'b0;
  logic [31:0] imem_addr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        ifid_valid;
  logic        ifid_ready = 1'b0;
  logic [31:0] inst, pc, snpc;
  logic        flush = 1'b0;
  logic        misalign;

  ysyx_22040750_ifu_pc dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_dnpc_valid (dnpc_valid),
    .O_dnpc_ready (dnpc_ready),
    .I_dnpc       (dnpc),
    .O_imem_req   (imem_req),
    .I_imem_gnt   (gnt),
    .O_imem_addr  (imem_addr),
    .I_imem_rvalid(rvalid),
    .I_imem_rdata (rdata),
    .O_IF_ID_valid(ifid_valid),
    .I_IF_ID_ready(ifid_ready),
    .O_inst       (inst),
    .O_pc         (pc),
    .O_snpc       (snpc),
    .I_flush      (flush),
    .O_misalign   (misalign)
  );

  always #5 clk = ~clk;

  // Reference model state: where the next fetch must go, what is owed to IF/ID
  logic [31:0] model_pc = RST_PC;
  bit          exp_mis  = 1'b0;
  bit          kill     = 1'b0;   // current instruction was flushed; its response is dropped
  logic [31:0] addr_q[$];
  logic [95:0] out_q[$];          // {inst, pc, snpc}
  bit          dn_hs, rq_hs;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance one cycle; before the edge, record what the stimulus just committed to
  task automatic tick();
    logic [31:0] dv;
    dn_hs = dnpc_ready && dnpc_valid;
    rq_hs = imem_req && gnt;
    dv    = dnpc;
    if (rq_hs) addr_q.push_back(model_pc);
    if (rvalid && !kill) out_q.push_back({rdata, model_pc, model_pc + 32'd4});
    if (flush && !dn_hs) begin
      out_q.delete();
      kill = 1'b1;
    end
    @(posedge clk); #1;
    if (dn_hs) begin
      model_pc = dv & ~32'h3;
      exp_mis  = exp_mis || (dv % 4 != 0);
      kill     = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dnpc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; ifid_ready = 1'b0; flush = 1'b0;
    model_pc = RST_PC; exp_mis = 1'b0; kill = 1'b0;
    addr_q.delete(); out_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_dnpc(input logic [31:0] a);
    dnpc = a; dnpc_valid = 1'b1;
    tick();
    dnpc_valid = 1'b0;
  endtask

  // Full fetch from S_REQ: grant, response next cycle, deliver
  task automatic fetch(input logic [31:0] w);
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = w; tick(); rvalid = 1'b0;
    chk("fetch_valid", {31'b0, ifid_valid}, 32'd1);
    ifid_ready = 1'b1; tick(); ifid_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every DUT handshake
  always @(negedge clk) begin
    logic [95:0] e;
    if (rst_n) begin
      if (imem_req && gnt) begin
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL imem_addr: unexpected request at %h", imem_addr);
        end else chk("imem_addr", imem_addr, addr_q.pop_front());
      end
      if (ifid_valid && ifid_ready && !flush) begin
        if (out_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL if_id: unexpected delivery pc=%h inst=%h", pc, inst);
        end else begin
          e = out_q.pop_front();
          chk("if_id_inst", inst, e[95:64]);
          chk("if_id_pc",   pc,   e[63:32]);
          chk("if_id_snpc", snpc, e[31:0]);
        end
      end
      chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
    end
  end

  initial begin
    bit       rv_pend;
    int       rv_dly;
    bit       done;

    do_reset();
    // Before the first post-release edge nothing is requested
    chk("rst_req",        {31'b0, imem_req},   32'd0);
    chk("rst_dnpc_ready", {31'b0, dnpc_ready}, 32'd0);
    chk("rst_valid",      {31'b0, ifid_valid}, 32'd0);
    chk("rst_pc",         pc,                  RST_PC);
    chk("rst_inst",       inst,                32'd0);
    tick();
    chk("first_req",  {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         RST_PC);

    // First fetch, IF/ID stalls for three cycles
    gnt = 1'b1; tick(); gnt = 1'b0;
    chk("rsp_req_low", {31'b0, imem_req}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_0413; tick(); rvalid = 1'b0;
    repeat (3) begin
      chk("hold_valid", {31'b0, ifid_valid}, 32'd1);
      chk("hold_pc",    pc,   32'h8000_0000);
      chk("hold_snpc",  snpc, 32'h8000_0004);
      chk("hold_inst",  inst, 32'h0000_0413);
      tick();
    end
    ifid_ready = 1'b1; tick(); ifid_ready = 1'b0;
    chk("npc_ready", {31'b0, dnpc_ready}, 32'd1);
    chk("npc_valid", {31'b0, ifid_valid}, 32'd0);

    // dnpc handshake -> request one cycle later; grant withheld five cycles
    send_dnpc(32'h8000_0010);
    repeat (5) begin
      chk("stall_req",   {31'b0, imem_req},   32'd1);
      chk("stall_addr",  imem_addr,           32'h8000_0010);
      chk("stall_ready", {31'b0, dnpc_ready}, 32'd0);
      tick();
    end

    // Flush while the response is outstanding; late response is dropped
    gnt = 1'b1; tick(); gnt = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    ifid_ready = 1'b1;
    repeat (2) begin
      chk("drop_valid", {31'b0, ifid_valid}, 32'd0);
      tick();
    end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; tick(); rvalid = 1'b0;
    ifid_ready = 1'b0;
    chk("drop_valid_after", {31'b0, ifid_valid}, 32'd0);
    chk("drop_npc_ready",   {31'b0, dnpc_ready}, 32'd1);

    // Misaligned dnpc: aligned fetch, sticky flag
    send_dnpc(32'h8000_0006);
    chk("mis_addr", imem_addr,         32'h8000_0004);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    fetch(32'h0010_0093);

    // Top-of-space pc: snpc wraps to zero
    send_dnpc(32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr,         32'hFFFF_FFFC);
    chk("wrap_snpc", snpc,              32'h0000_0000);
    chk("mis_stick", {31'b0, misalign}, 32'd1);
    fetch(32'h0000_0073);

    // Flush together with IF/ID ready in S_OUT: not delivered
    send_dnpc(32'h8000_0100);
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678; tick(); rvalid = 1'b0;
    flush = 1'b1; ifid_ready = 1'b1; tick(); flush = 1'b0; ifid_ready = 1'b0;
    chk("oflush_valid", {31'b0, ifid_valid}, 32'd0);
    chk("oflush_ready", {31'b0, dnpc_ready}, 32'd1);

    // Flush together with dnpc in S_NPC: dnpc wins
    flush = 1'b1; send_dnpc(32'h8000_0200); flush = 1'b0;
    chk("nflush_req",  {31'b0, imem_req}, 32'd1);
    chk("nflush_addr", imem_addr,         32'h8000_0200);
    fetch(32'h0051_0113);

    // Flush in S_REQ before grant: back to waiting for dnpc
    send_dnpc(32'h8000_0300);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("rflush_req",   {31'b0, imem_req},   32'd0);
    chk("rflush_ready", {31'b0, dnpc_ready}, 32'd1);

    // Async reset pulse off the clock edge while the response is outstanding
    send_dnpc(32'h8000_0400);
    gnt = 1'b1; tick(); gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'b0, imem_req},   32'd0);
    chk("arst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("arst_ready", {31'b0, dnpc_ready}, 32'd0);
    chk("arst_mis",   {31'b0, misalign},   32'd0);
    chk("arst_pc",    pc,                  RST_PC);
    chk("arst_inst",  inst,                32'd0);
    do_reset();
    // The abandoned request's response shows up late and must be ignored
    kill = 1'b1; rvalid = 1'b1; rdata = 32'hBAD0_BAD0; tick(); rvalid = 1'b0; kill = 1'b0;
    chk("refetch_req",  {31'b0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr,         RST_PC);
    fetch($urandom);

    // Randomized traffic: grant/response/ready/dnpc timing all random
    rv_pend = 1'b0; rv_dly = 0;
    for (int i = 0; i < 3000; i++) begin
      gnt = imem_req ? ($urandom_range(0, 2) == 0) : 1'b0;
      rvalid = 1'b0;
      if (rv_pend) begin
        if (rv_dly == 0) begin rvalid = 1'b1; rdata = $urandom; rv_pend = 1'b0; end
        else rv_dly--;
      end
      ifid_ready = 1'($urandom_range(0, 1));
      if (!dnpc_valid && $urandom_range(0, 1) == 1) begin
        dnpc_valid = 1'b1;
        dnpc = $urandom;
        if ($urandom_range(0, 15) != 0) dnpc[1:0] = 2'b00;
      end
      tick();
      if (rq_hs) begin rv_pend = 1'b1; rv_dly = $urandom_range(0, 3); end
      if (dn_hs) dnpc_valid = 1'b0;
    end

    // Drain: finish the in-flight instruction and park in S_NPC
    dnpc_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (dnpc_ready) done = 1'b1;
      else begin
        gnt = imem_req;
        rvalid = 1'b0;
        if (rv_pend) begin rvalid = 1'b1; rdata = $urandom; rv_pend = 1'b0; end
        ifid_ready = 1'b1;
        tick();
        if (rq_hs) rv_pend = 1'b1;
      end
    end
    gnt = 1'b0; rvalid = 1'b0; ifid_ready = 1'b0;
    chk("drain_done",   {31'b0, done}, 32'd1);
    chk("drain_addr_q", addr_q.size(), 32'd0);
    chk("drain_out_q",  out_q.size(),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
